serial_adder_seq: RTL
=====================

// Module: serial_adder_seq
// PURPOSE
//  Bit-serial adder: one full-adder cell plus a registered carry adds two WIDTH-bit operands, one bit per clock, LSB first.
//  It is the sequential stage wrapped around the combinational full adder.
//  It feeds the cell one operand bit pair per cycle and holds carry between cycles.
//  It collects the sum bits and returns the result with a start/done handshake.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range WIDTH >= 1
// PORTS
//  clk      in   1      rising-edge clock
//  rst_n    in   1      asynchronous, active-low reset
//  start    in   1      request; sampled only in IDLE
//  a_in     in   WIDTH  operand A, captured on accepted start
//  b_in     in   WIDTH  operand B, captured on accepted start
//  cin      in   1      carry-in, captured on accepted start
//  busy     out  1      1 while in RUN
//  done     out  1      1-cycle pulse in DONE; result valid from this cycle
//  sum_out  out  WIDTH  registered sum; held until the next completion
//  cout     out  1      registered final carry; held like sum_out
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; busy=0, done=0, sum_out=0, cout=0.
//   - Shift registers, carry register and bit counter cleared.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: start=1 at edge E0 loads a_in and b_in into shift regs, cin into carry reg, count=0, and moves to RUN.
//   - RUN: each edge the full-adder cell takes sa[0], sb[0] and carry.
//     - sum bit shifts into the MSB of a result shift reg (right shift).
//     - carry <= carry-out; sa and sb shift right; count++.
//     - At edges E1..E(WIDTH), bits 0..WIDTH-1 are processed.
//     - At edge E(WIDTH), the final carry goes to cout, the assembled result goes to sum_out, and the state moves to DONE.
//   - DONE: done=1 for exactly one cycle; next edge returns to IDLE unconditionally.
//  Latency:
//   - done is high in the cycle after edge E(WIDTH), i.e. WIDTH+1 edges after the start edge.
//   - Throughput is one add per WIDTH+2 cycles.
//  busy=1 only in RUN; busy and done are never high together.
//  start in RUN or DONE is ignored; it is not queued. Operand inputs are don't-care outside the accepting edge.
//  sum_out and cout change only at the RUN->DONE edge or on reset. No partial results are visible.
//  Arithmetic: {cout,sum_out} = a_in + b_in + cin, exact and modulo 2^(WIDTH+1); no overflow flag.
//  Counter width is $clog2(WIDTH+1). WIDTH=1 gives one RUN cycle.
//  Reset mid-RUN or mid-DONE:
//   - Immediate return to the reset values; the in-flight operation is discarded.
//   - A done pulse cut short by reset is not reissued.
// TESTING
//  1. A=8'hA5, B=8'h3C, cin=0, start at E0:
//     - busy high E1..E8; done=1 after E8 only.
//     - sum_out=8'hE1, cout=0.
//  2. A=8'hFF, B=8'h01, cin=0 -> sum_out=8'h00, cout=1 (full carry ripple through every bit).
//  3. A=8'hFF, B=8'hFF, cin=1 -> sum_out=8'hFF, cout=1.
//     Then A=0, B=0, cin=0 -> sum_out=8'h00, cout=0, and both hold after done drops.
//  4. Held start:
//     - start held high during RUN with new operands 8'h11/8'h22 -> first result unaffected, no extra done.
//     - start still high in the IDLE cycle after DONE -> second add accepted; result 8'h33, cout=0.
//  5. rst_n pulsed low after E4 of an add:
//     - busy, done, sum_out and cout drop to 0 asynchronously (before the next clock edge).
//     - A fresh start of 8'h01+8'h01 -> 8'h02 after WIDTH+1 edges.
//  6. Random sweep, WIDTH=8 and WIDTH=1, 1000 random operand/cin sets:
//     - {cout,sum_out} == a+b+cin every time.
//     - done-to-start spacing is exactly WIDTH+1 edges.

Source files
------------

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: one full-adder cell and a carry flop add two WIDTH-bit operands
// LSB first, one bit per clock, with a start/done handshake around the sequence.
module serial_adder_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Returns {carry_out, sum} of a single full-adder cell.
   function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
      full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
   endfunction

   state_t           state_r, state_s;
   logic [WIDTH-1:0] sa_r, sa_s, sb_r, sb_s, res_r, res_s, res_shift_s;
   logic [WIDTH-1:0] sum_r, sum_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic             carry_r, carry_s, cout_r, cout_s;
   logic             busy_r, busy_s, done_r, done_s;
   logic [1:0]       fa_s;

   // Next-state, datapath and output decode for the IDLE/RUN/DONE sequence.
   always_comb begin
      state_s     = state_r;
      sa_s        = sa_r;
      sb_s        = sb_r;
      res_s       = res_r;
      cnt_s       = cnt_r;
      carry_s     = carry_r;
      sum_s       = sum_r;
      cout_s      = cout_r;
      fa_s        = full_add(sa_r[0], sb_r[0], carry_r);
      res_shift_s = res_r >> 1'b1;
      res_shift_s[WIDTH-1] = fa_s[0];

      case (state_r)
         ST_IDLE: begin
            if (start) begin
               sa_s    = a_in;
               sb_s    = b_in;
               carry_s = cin;
               cnt_s   = '0;
               state_s = ST_RUN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            sa_s    = sa_r >> 1'b1;
            sb_s    = sb_r >> 1'b1;
            res_s   = res_shift_s;
            carry_s = fa_s[1];
            // Last bit pair: publish the whole result and final carry together.
            if (cnt_r == CNT_W'(WIDTH - 1)) begin
               sum_s   = res_shift_s;
               cout_s  = fa_s[1];
               cnt_s   = '0;
               state_s = ST_DONE;
            end else begin
               cnt_s   = cnt_r + CNT_W'(1);
               state_s = ST_RUN;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      busy_s = (state_s == ST_RUN);
      done_s = (state_s == ST_DONE);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         sa_r    <= '0;
         sb_r    <= '0;
         res_r   <= '0;
         cnt_r   <= '0;
         carry_r <= 1'b0;
         sum_r   <= '0;
         cout_r  <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         sa_r    <= sa_s;
         sb_r    <= sb_s;
         res_r   <= res_s;
         cnt_r   <= cnt_s;
         carry_r <= carry_s;
         sum_r   <= sum_s;
         cout_r  <= cout_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign sum_out = sum_r;
   assign cout    = cout_r;

endmodule
